// File: rtl/vc_input_bank.sv
// Per-VC input buffering with wormhole output arbitration; optional occupancy port (VC_INPUT_BANK_OCUP_EN).
// Latency: a written flit is first presented one cycle after its write; output grant is same-cycle.
// Backpressure: ready_o is !full of the addressed VC; the presented flit is held stable while ready_i is low.

module vc_fifo #(
    parameter int W     = 34,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         arst,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    input  logic         rd_rdy,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] rd_dat
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [W-1:0]  mem [DEPTH];

    // Extra pointer MSB tells a full ring apart from an empty one.
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign rd_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (arst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_vld) wr_ptr <= wr_ptr + PW'(1);
            if (rd_rdy) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_vld) mem[wr_ptr[AW-1:0]] <= wr_dat;
    end
endmodule

module vc_input_bank #(
    parameter int FLIT_WIDTH = 34,
    parameter int NUM_VC     = 4,
    parameter int VC_DEPTH   = 4
) (
    input  logic                      clk,
    input  logic                      arst,
    input  logic [FLIT_WIDTH-1:0]     fdata_i,
    input  logic [$clog2(NUM_VC)-1:0] vc_id_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    output logic [FLIT_WIDTH-1:0]     fdata_o,
    output logic [$clog2(NUM_VC)-1:0] vc_id_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic                      error_o
`ifdef VC_INPUT_BANK_OCUP_EN
    ,
    output logic [NUM_VC*($clog2(VC_DEPTH)+1)-1:0] ocup_o
`endif
);
    localparam int VCW  = $clog2(NUM_VC);
    localparam int CW   = $clog2(VC_DEPTH) + 1;
    localparam int NPAD = 1 << VCW;

    localparam logic [1:0] T_HEAD = 2'b00;
    localparam logic [1:0] T_TAIL = 2'b11;

    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

    logic [NUM_VC-1:0]     full_vec;
    logic [NUM_VC-1:0]     empty_vec;
    logic [NUM_VC-1:0]     in_lock;
    logic [NUM_VC-1:0]     push_vec;
    logic [NUM_VC-1:0]     pop_vec;
    logic [FLIT_WIDTH-1:0] head_dat [NUM_VC];
    logic [NPAD-1:0]       full_pad;
    logic [NPAD-1:0]       lock_pad;

    logic [1:0] in_typ;
    logic       in_head;
    logic       in_tail;
    logic       in_legal;
    logic       in_accept;
    logic       wr_en;
    logic       error_q;

    arb_state_t     state_q, state_d;
    logic [VCW-1:0] lock_vc_q, lock_vc_d;
    logic [VCW-1:0] rr_ptr_q, rr_ptr_d;
    logic [VCW-1:0] hold_vc_q, hold_vc_d;
    logic           hold_q, hold_d;
    logic [VCW-1:0] rr_vc;
    logic           rr_vld;
    logic [VCW-1:0] sel_vc;
    logic           sel_vld;
    logic           out_vld;
    logic           hs;
    logic [1:0]     out_typ;

    // Unused VC codes (non power-of-two NUM_VC) look full, so they are never accepted.
    always_comb begin
        full_pad               = '1;
        full_pad[NUM_VC-1:0]   = full_vec;
        lock_pad               = '0;
        lock_pad[NUM_VC-1:0]   = in_lock;
    end

    assign in_typ    = fdata_i[FLIT_WIDTH-1 -: 2];
    assign in_head   = (in_typ == T_HEAD);
    assign in_tail   = (in_typ == T_TAIL);
    assign in_legal  = in_head ? !lock_pad[vc_id_i] : lock_pad[vc_id_i];
    assign ready_o   = arst || !full_pad[vc_id_i];
    assign in_accept = valid_i && ready_o && !arst;
    assign wr_en     = in_accept && in_legal;
    assign error_o   = error_q && !arst;

    for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
        assign push_vec[g] = wr_en && (vc_id_i == VCW'(g));
        assign pop_vec[g]  = hs && (sel_vc == VCW'(g));

        vc_fifo #(
            .W     (FLIT_WIDTH),
            .DEPTH (VC_DEPTH)
        ) u_fifo (
            .clk    (clk),
            .arst   (arst),
            .wr_vld (push_vec[g]),
            .wr_dat (fdata_i),
            .rd_rdy (pop_vec[g]),
            .full   (full_vec[g]),
            .empty  (empty_vec[g]),
            .rd_dat (head_dat[g])
        );
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            in_lock <= '0;
            error_q <= 1'b0;
        end else begin
            error_q <= in_accept && !in_legal;
            if (wr_en) begin
                if (in_head)      in_lock[vc_id_i] <= 1'b1;
                else if (in_tail) in_lock[vc_id_i] <= 1'b0;
            end
        end
    end

    // Round-robin search; walking backwards leaves the nearest non-empty VC selected.
    always_comb begin
        int idx;
        idx    = 0;
        rr_vld = 1'b0;
        rr_vc  = '0;
        for (int i = NUM_VC - 1; i >= 0; i--) begin
            idx = (int'(rr_ptr_q) + i) % NUM_VC;
            if (!empty_vec[idx]) begin
                rr_vld = 1'b1;
                rr_vc  = idx[VCW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state_q   <= ARB_IDLE;
            lock_vc_q <= '0;
            rr_ptr_q  <= '0;
            hold_q    <= 1'b0;
            hold_vc_q <= '0;
        end else begin
            state_q   <= state_d;
            lock_vc_q <= lock_vc_d;
            rr_ptr_q  <= rr_ptr_d;
            hold_q    <= hold_d;
            hold_vc_q <= hold_vc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lock_vc_d = lock_vc_q;
        rr_ptr_d  = rr_ptr_q;
        hold_d    = hold_q;
        hold_vc_d = hold_vc_q;
        sel_vc    = rr_vc;
        sel_vld   = rr_vld;

        case (state_q)
            ARB_IDLE: begin
                // A stalled IDLE grant is pinned so a newly filled VC cannot displace it.
                if (hold_q) begin
                    sel_vc  = hold_vc_q;
                    sel_vld = !empty_vec[hold_vc_q];
                end
            end
            ARB_LOCKED: begin
                sel_vc  = lock_vc_q;
                sel_vld = !empty_vec[lock_vc_q];
            end
            default: ;
        endcase

        out_vld = sel_vld && !arst;
        hs      = out_vld && ready_i;
        out_typ = head_dat[sel_vc][FLIT_WIDTH-1 -: 2];

        case (state_q)
            ARB_IDLE: begin
                hold_d    = out_vld && !ready_i;
                hold_vc_d = sel_vc;
                if (hs && (out_typ == T_HEAD)) begin
                    state_d   = ARB_LOCKED;
                    lock_vc_d = sel_vc;
                end
            end
            ARB_LOCKED: begin
                if (hs && (out_typ == T_TAIL)) begin
                    state_d  = ARB_IDLE;
                    rr_ptr_d = (sel_vc == VCW'(NUM_VC - 1)) ? '0 : sel_vc + VCW'(1);
                end
            end
            default: ;
        endcase
    end

    assign valid_o = out_vld;
    assign fdata_o = out_vld ? head_dat[sel_vc] : '0;
    assign vc_id_o = out_vld ? sel_vc : '0;

`ifdef VC_INPUT_BANK_OCUP_EN
    logic [CW-1:0] ocup_q [NUM_VC];

    always_ff @(posedge clk) begin
        if (arst) begin
            for (int v = 0; v < NUM_VC; v++) ocup_q[v] <= '0;
        end else begin
            for (int v = 0; v < NUM_VC; v++)
                ocup_q[v] <= ocup_q[v] + CW'(push_vec[v]) - CW'(pop_vec[v]);
        end
    end

    for (genvar g = 0; g < NUM_VC; g++) begin : g_ocup
        assign ocup_o[g*CW +: CW] = ocup_q[g];
    end
`endif
endmodule

// File: doc/vc_input_bank.md
VC_INPUT_BANK -- requirements
Module: vc_input_bank

Interface
REQ-001 Parameter FLIT_WIDTH, default 34; flit width in bits, with the flit type in bits [FLIT_WIDTH-1:FLIT_WIDTH-2]. Legal range is >= 4.
REQ-002 Parameter NUM_VC, default 4; number of virtual channels. Legal range is 2..8.
REQ-003 Parameter VC_DEPTH, default 4; FIFO entries per VC. Power of two, >= 2.
REQ-004 Port clk, input, 1; sole clock, rising edge.
REQ-005 Port arst, input, 1; synchronous, active-high reset.
REQ-006 Port fdata_i, input, FLIT_WIDTH; incoming flit.
REQ-007 Port vc_id_i, input, clog2(NUM_VC); target VC of the incoming flit.
REQ-008 Port valid_i, input, 1; incoming flit valid.
REQ-009 Port ready_o, output, 1; bank accepts the flit on vc_id_i.
REQ-010 Port fdata_o, output, FLIT_WIDTH; outgoing flit.
REQ-011 Port vc_id_o, output, clog2(NUM_VC); VC of the outgoing flit.
REQ-012 Port valid_o, output, 1; outgoing flit valid.
REQ-013 Port ready_i, input, 1; downstream accepts the outgoing flit.
REQ-014 Port error_o, output, 1; one-cycle pulse when a protocol-violating flit is dropped.

Function
REQ-015 Flit type encoding: 2'b00 is HEAD, 2'b01 and 2'b10 are BODY, 2'b11 is TAIL.
REQ-016 Each VC is a first-word-fall-through FIFO of VC_DEPTH entries, using (clog2(VC_DEPTH)+1)-bit read and write pointers that wrap modulo 2*VC_DEPTH.
  - empty: pointers are equal.
  - full: low bits are equal and MSBs differ.
REQ-017 Each VC has an input lock bit:
  - an accepted HEAD sets it;
  - an accepted TAIL clears it;
  - BODY leaves it unchanged.
REQ-018 ready_o SHALL be combinational, equal to !full[vc_id_i], computed from registered pointers only. It does not depend on a same-cycle read.
REQ-019 Write occurs at the clk edge when valid_i && ready_o && legal.
  - Legal means: HEAD while the VC is unlocked, or BODY/TAIL while the VC is locked.
  - An illegal flit with valid_i && ready_o is consumed but not stored, and error_o pulses high in the following cycle.
REQ-020 A written flit is visible at the FIFO head no earlier than the next cycle. There is no same-cycle bypass.
REQ-021 Output arbiter FSM states are IDLE and LOCKED(v).
  - In IDLE, grant the first non-empty VC at or after rr_ptr (round robin, wrapping).
  - The grant is combinational: valid_o=1 in the same cycle.
REQ-022 In LOCKED(v):
  - vc_id_o=v and fdata_o=head of VC v;
  - valid_o=!empty[v];
  - other VCs are not presented.
REQ-023 Transitions:
  - IDLE -> LOCKED(v) on a HEAD handshake (valid_o && ready_i);
  - LOCKED(v) -> IDLE on a TAIL handshake, with rr_ptr <= v+1 mod NUM_VC.
REQ-024 The read pointer of the presented VC increments on a valid_o && ready_i handshake only.
REQ-025 When valid_o=0, fdata_o is all zero and vc_id_o is 0.
REQ-026 Simultaneous write and read on the same VC in one cycle SHALL both take effect, leaving occupancy unchanged.
REQ-027 valid_o and fdata_o SHALL remain stable while valid_o && !ready_i.

Reset
REQ-028 While arst=1 at a clk edge, the following are cleared to zero, discarding all stored flits:
  - all pointers;
  - all input lock bits;
  - arbiter state to IDLE;
  - rr_ptr;
  - error_o.
REQ-029 While arst=1 and in the cycle after it is released: ready_o=1, valid_o=0, error_o=0. FIFO storage contents need not be reset.
REQ-030 Reset asserted mid-packet SHALL abort the packet. The next flit on that VC must be a HEAD, otherwise it is dropped with error_o.

Configuration
REQ-031 Macro VC_INPUT_BANK_OCUP_EN controls an occupancy output.
  - When defined: output port ocup_o, width NUM_VC*(clog2(VC_DEPTH)+1), is present. Slice v is the registered entry count of VC v (0..VC_DEPTH), updated at the clk edge after each write or read.
  - When undefined: the port and its logic are absent, and all other behaviour is identical.

Verification
REQ-032 Reset, then HEAD/BODY/TAIL (type 00/01/11) into VC 1 on consecutive cycles -> the three flits appear on fdata_o with vc_id_o=1 in order, with the first valid_o one cycle after the HEAD write.
REQ-033 Defaults, ready_i=0, write 4 HEAD+BODY flits into VC 2 -> ready_o=0 when vc_id_i=2 and ready_o=1 when vc_id_i=0. A 5th write is not stored. Then ready_i=1 -> exactly 4 flits drain.
REQ-034 BODY sent to unlocked VC 0 -> not stored, error_o=1 for exactly one cycle. HEAD sent to locked VC 0 -> same behaviour.
REQ-035 Complete packets pending on VCs 0, 1 and 3, ready_i=1 -> packets are output whole and in order 0, 1, 3, with no interleaving of flits between VCs.
REQ-036 arst pulsed after the HEAD and one BODY of a packet -> valid_o=0 and ready_o=1 after reset. A following TAIL causes error_o. With VC_INPUT_BANK_OCUP_EN defined, ocup_o is all zero.
